// File: rtl/freq_gate_counter_if.sv
// freq_gate_counter_if: measurement bus (SIG_IN/START/CONT in, FREQ_OUT/FREQ_VALID/BUSY/OVERFLOW out)
interface freq_gate_counter_if #(
  parameter int COUNT_W = 27
);
  logic               SIG_IN;
  logic               START;
  logic               CONT;
  logic [COUNT_W-1:0] FREQ_OUT;
  logic               FREQ_VALID;
  logic               BUSY;
  logic               OVERFLOW;
  modport master (
    output SIG_IN, START, CONT,
    input  FREQ_OUT, FREQ_VALID, BUSY, OVERFLOW
  );
  modport slave (
    input  SIG_IN, START, CONT,
    output FREQ_OUT, FREQ_VALID, BUSY, OVERFLOW
  );
endinterface

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts SIG_IN rising edges over a GATE_CYCLES window and latches the result
// Ports: CLK, RST (async, active-high), bus (slave): SIG_IN, START, CONT in; FREQ_OUT, FREQ_VALID, BUSY, OVERFLOW out.
// FREQ_COUNT_SAT_EN: edge counter saturates instead of wrapping.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int COUNT_W     = 27,
  parameter int SYNC_STAGES = 2
) (
  input logic                CLK,
  input logic                RST,
  freq_gate_counter_if.slave bus
);
  localparam int GW = $clog2(GATE_CYCLES);
  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;
  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic               hist, rise, gate_done, at_max;
  logic [GW-1:0]      gate_cnt;
  logic [COUNT_W-1:0] cnt, cnt_nxt, cnt_inc, freq, freq_nxt;
  logic               ovf, ovf_nxt, ovf_out, ovf_out_nxt, valid, valid_nxt, busy, busy_nxt;
  // Resetting to 1 keeps an input that is already high from looking like a rise.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.SIG_IN};
      hist <= sync[SYNC_STAGES-1];
    end
  assign rise = sync[SYNC_STAGES-1] & ~hist;
  assign gate_done = gate_cnt == GW'(GATE_CYCLES - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? ((bus.START | bus.CONT) ? ARM : IDLE) :
                state == ARM  ? GATE :
                state == GATE ? (gate_done ? LATCH : GATE) :
                (bus.CONT ? ARM : IDLE);
  assign at_max = &cnt;
`ifdef FREQ_COUNT_SAT_EN
  assign cnt_inc = at_max ? cnt : cnt + COUNT_W'(1);
`else
  assign cnt_inc = cnt + COUNT_W'(1);
`endif
  always_comb begin
    cnt_nxt = state == ARM ? '0 : (state == GATE && rise) ? cnt_inc : cnt;
    ovf_nxt = state == ARM ? 1'b0 : ovf | (state == GATE && rise && at_max);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      gate_cnt <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      gate_cnt <= state == ARM ? '0 : state == GATE ? gate_cnt + GW'(1) : gate_cnt;
      cnt      <= cnt_nxt;
      ovf      <= ovf_nxt;
    end
  // Outputs are registered from the next state so they line up with the state they describe;
  // the latched count includes an edge seen in the final gate cycle.
  always_comb begin
    valid_nxt   = state_nxt == LATCH;
    busy_nxt    = state_nxt != IDLE;
    freq_nxt    = state_nxt == LATCH ? cnt_nxt : freq;
    ovf_out_nxt = state_nxt == LATCH ? ovf_nxt : ovf_out;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      freq    <= '0;
      ovf_out <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      freq    <= freq_nxt;
      ovf_out <= ovf_out_nxt;
      valid   <= valid_nxt;
      busy    <= busy_nxt;
    end
  assign bus.FREQ_OUT   = freq;
  assign bus.OVERFLOW   = ovf_out;
  assign bus.FREQ_VALID = valid;
  assign bus.BUSY       = busy;
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: scoreboard bench for freq_gate_counter with GATE_CYCLES=100
module tb_freq_gate_counter;
  logic clk, rst;
  int   cyc = 0, tests = 0, fails = 0, per = 0, ph = 0;
  logic hold = 1'b1, s;
  typedef struct {int c; longint f; logic o;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
`ifdef FREQ_COUNT_SAT_EN
  localparam longint OVF_F = 15;
`else
  localparam longint OVF_F = 2;
`endif
  freq_gate_counter_if #(.COUNT_W(27)) b0();
  freq_gate_counter_if #(.COUNT_W(4))  b1();
  freq_gate_counter #(.GATE_CYCLES(100), .COUNT_W(27), .SYNC_STAGES(2)) dut0 (.CLK(clk), .RST(rst), .bus(b0));
  freq_gate_counter #(.GATE_CYCLES(100), .COUNT_W(4),  .SYNC_STAGES(2)) dut1 (.CLK(clk), .RST(rst), .bus(b1));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask
  // per cycles per period (high for per/2), or a constant level when per is 0
  initial forever begin
    @(negedge clk);
    if (per == 0) s = hold;
    else begin
      s  = (ph % per) < per / 2;
      ph = (ph + 1) % per;
    end
    b0.SIG_IN = s;
    b1.SIG_IN = s;
  end
  initial forever begin
    @(negedge clk);
    if (b0.FREQ_VALID === 1'b1) begin
      if (q0.size() == 0) chk("dut0 unexpected strobe", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("dut0 strobe cycle", cyc, e0.c);
        chk("dut0 freq", b0.FREQ_OUT, e0.f);
        chk("dut0 overflow", b0.OVERFLOW, e0.o);
      end
    end
    if (b1.FREQ_VALID === 1'b1) begin
      if (q1.size() == 0) chk("dut1 unexpected strobe", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("dut1 strobe cycle", cyc, e1.c);
        chk("dut1 freq", b1.FREQ_OUT, e1.f);
        chk("dut1 overflow", b1.OVERFLOW, e1.o);
      end
    end
  end
  task automatic go(input logic s0, input logic s1, output int t0);
    @(negedge clk);
    b0.START = s0;
    b1.START = s1;
    t0 = cyc;
    @(negedge clk);
    b0.START = 1'b0;
    b1.START = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("pending results", q0.size() + q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int t0, bad;
    rst = 1'b1;
    b0.START = 1'b0; b0.CONT = 1'b0; b0.SIG_IN = 1'b1;
    b1.START = 1'b0; b1.CONT = 1'b0; b1.SIG_IN = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset freq", b0.FREQ_OUT, 0);
    chk("reset valid", b0.FREQ_VALID, 0);
    chk("reset busy", b0.BUSY, 0);
    chk("reset overflow", b0.OVERFLOW, 0);
    chk("reset dut1 busy", b1.BUSY, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    go(1'b1, 1'b0, t0);
    q0.push_back('{t0 + 102, 0, 1'b0});
    drain();
    per = 10;
    repeat (20) @(negedge clk);
    go(1'b1, 1'b0, t0);
    q0.push_back('{t0 + 102, 10, 1'b0});
    bad = 0;
    for (int k = 1; k <= 103; k++) begin
      if (b0.BUSY !== (k <= 102)) bad++;
      @(negedge clk);
    end
    chk("busy window errors", bad, 0);
    drain();
    per = 2;
    repeat (10) @(negedge clk);
    go(1'b1, 1'b1, t0);
    q0.push_back('{t0 + 102, 50, 1'b0});
    q1.push_back('{t0 + 102, OVF_F, 1'b1});
    drain();
    per = 5;
    repeat (10) @(negedge clk);
    @(negedge clk);
    b0.CONT = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 3; k++) q0.push_back('{t0 + 102 * k, 20, 1'b0});
    repeat (250) @(negedge clk);
    b0.CONT = 1'b0;
    repeat (57) @(negedge clk);
    chk("busy after cont drop", b0.BUSY, 0);
    drain();
    per = 10;
    repeat (20) @(negedge clk);
    go(1'b1, 1'b0, t0);
    repeat (51) @(negedge clk);
    chk("busy before mid reset", b0.BUSY, 1);
    rst = 1'b1;
    #1;
    chk("mid reset freq", b0.FREQ_OUT, 0);
    chk("mid reset busy", b0.BUSY, 0);
    chk("mid reset valid", b0.FREQ_VALID, 0);
    chk("mid reset overflow", b0.OVERFLOW, 0);
    chk("mid reset dut1 freq", b1.FREQ_OUT, 0);
    chk("mid reset dut1 overflow", b1.OVERFLOW, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    go(1'b1, 1'b0, t0);
    q0.push_back('{t0 + 102, 10, 1'b0});
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
